// File: rtl/telegraph_pkg.sv
// Shared types and constants for the telegraph receiver.
package telegraph_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    GAP  = 2'd2,
    WORD = 2'd3
  } state_t;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  // Timing thresholds, in multiples of one Morse unit
  localparam int DASH_MULT = 2;
  localparam int CHAR_MULT = 2;
  localparam int WORD_MULT = 5;

endpackage

// File: rtl/telegraph_line_filter.sv
// Line input conditioning: 2-flop synchronizer, plus an optional glitch
// filter enabled by TELEGRAPH_DEBOUNCE_EN. Output s is the level the
// receiver FSM times.
module telegraph_line_filter #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic s
);

  logic [1:0] sync;

  // Bring the asynchronous relay level into the clock domain
  always_ff @(posedge clk) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], line_in};
  end

`ifdef TELEGRAPH_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DW-1:0] dcnt;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive samples of it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s    <= 1'b0;
      dcnt <= '0;
    end else if (sync[1] == s) begin
      dcnt <= '0;
    end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      s    <= sync[1];
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end
`else
  localparam int unused_debounce = DEBOUNCE_CYCLES;

  assign s = sync[1];
`endif

endmodule

// File: rtl/telegraph_receiver.sv
// Relay telegraph receiver: times marks and spaces on the conditioned line,
// decodes dots/dashes and strobes out each character and each word gap.
// Optional glitch filter on the line input: TELEGRAPH_DEBOUNCE_EN.
module telegraph_receiver
  import telegraph_pkg::*;
#(
  parameter int UNIT_CYCLES     = 4,
  parameter int MAX_SYMBOLS     = 6,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               line_in,
  output logic                               char_valid,
  output logic [MAX_SYMBOLS-1:0]             char_code,
  output logic [$clog2(MAX_SYMBOLS+1)-1:0]   char_len,
  output logic                               char_err,
  output logic                               word_gap
);

  localparam int DASH_T = DASH_MULT * UNIT_CYCLES;
  localparam int CHAR_T = CHAR_MULT * UNIT_CYCLES;
  localparam int WORD_T = WORD_MULT * UNIT_CYCLES;
  localparam int CW     = $clog2(WORD_T + 1);
  localparam int LW     = $clog2(MAX_SYMBOLS + 1);

  logic                   s;
  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx, cnt_sat;
  logic [MAX_SYMBOLS-1:0] code, code_nx;
  logic [LW-1:0]          len, len_nx;
  logic                   err, err_nx;
  logic                   emit_char, emit_word;

  telegraph_line_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (line_in),
    .s       (s)
  );

  // Next state, run-length counter and symbol assembly; thresholds win over
  // a mark starting on the same cycle
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    code_nx   = code;
    len_nx    = len;
    err_nx    = err;
    emit_char = 1'b0;
    emit_word = 1'b0;
    cnt_sat   = (cnt == CW'(WORD_T)) ? cnt : cnt + 1'b1;

    unique case (state)
      IDLE: begin
        if (s) begin
          state_nx = MARK;
          cnt_nx   = CW'(1);
        end else begin
          cnt_nx = cnt_sat;
        end
      end
      MARK: begin
        if (s) begin
          cnt_nx = cnt_sat;
        end else begin
          state_nx = GAP;
          cnt_nx   = CW'(1);
          if (len < LW'(MAX_SYMBOLS)) begin
            for (int i = 0; i < MAX_SYMBOLS; i++)
              if (LW'(i) == len)
                code_nx[i] = (cnt >= CW'(DASH_T)) ? SYM_DASH : SYM_DOT;
            len_nx = len + 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt == CW'(CHAR_T)) begin
          state_nx  = WORD;
          cnt_nx    = cnt_sat;
          emit_char = 1'b1;
          code_nx   = '0;
          len_nx    = '0;
          err_nx    = 1'b0;
        end else if (s) begin
          state_nx = MARK;
          cnt_nx   = CW'(1);
        end else begin
          cnt_nx = cnt_sat;
        end
      end
      WORD: begin
        if (cnt == CW'(WORD_T)) begin
          state_nx  = IDLE;
          emit_word = 1'b1;
        end else if (s) begin
          state_nx = MARK;
          cnt_nx   = CW'(1);
        end else begin
          cnt_nx = cnt_sat;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, assembler and registered output strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      code       <= '0;
      len        <= '0;
      err        <= 1'b0;
      char_valid <= 1'b0;
      char_code  <= '0;
      char_len   <= '0;
      char_err   <= 1'b0;
      word_gap   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      code       <= code_nx;
      len        <= len_nx;
      err        <= err_nx;
      char_valid <= emit_char;
      char_code  <= emit_char ? code : '0;
      char_len   <= emit_char ? len : '0;
      char_err   <= emit_char & err;
      word_gap   <= emit_word;
    end
  end

endmodule

// File: tb/tb_telegraph_receiver.sv
// Bench for telegraph_receiver: directed and random line patterns, checked
// cycle by cycle against a run-length model of the Morse timing rules.
module tb_telegraph_receiver;

  localparam int U      = 4;
  localparam int MS     = 6;
  localparam int DB     = 3;
  localparam int LW     = $clog2(MS + 1);
  localparam int DASH_T = 2 * U;
  localparam int CHAR_T = 2 * U;
  localparam int WORD_T = 5 * U;
  localparam int MAXN   = 512;
`ifdef TELEGRAPH_DEBOUNCE_EN
  localparam int DBEN = 1;
`else
  localparam int DBEN = 0;
`endif
  // line_in fall to first low level seen by the timing logic
  localparam int LAT = 2 + DBEN * DB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          line_in = 1'b0;
  logic          char_valid;
  logic [MS-1:0] char_code;
  logic [LW-1:0] char_len;
  logic          char_err;
  logic          word_gap;

  telegraph_receiver #(
    .UNIT_CYCLES     (U),
    .MAX_SYMBOLS     (MS),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_in    (line_in),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_len   (char_len),
    .char_err   (char_err),
    .word_gap   (word_gap)
  );

  always #5 clk = ~clk;

  bit          lv   [MAXN];
  bit          s_m  [MAXN];
  bit          e_cv [MAXN];
  bit          e_wg [MAXN];
  logic [MS-1:0] e_code [MAXN];
  int          e_len [MAXN];
  bit          e_err [MAXN];
  int          n;
  int          vectors = 0;
  int          errors  = 0;

  int            o_ncv, o_nwg, o_cv_at, o_cv_last, o_wg_at, o_len;
  logic [MS-1:0] o_code;
  bit            o_err;

  task automatic chk(input string tag, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s @%0d: observed %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic add(input bit lvl, input int len);
    for (int i = 0; i < len; i++)
      if (n < MAXN) begin
        lv[n] = lvl;
        n++;
      end
  endtask

  function automatic bit lv_at(input int i);
    return (i >= 0 && i < n) ? lv[i] : 1'b0;
  endfunction

  // Expected strobes from the line pattern: first the level seen per clock
  // edge, then a walk over mark/space runs applying the Morse rules.
  function automatic void build_expect();
    bit f, stable, found;
    int t, m, g, t0, u, len;
    logic [MS-1:0] code;
    bit err;
    f = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (DBEN != 0) begin
        s_m[k] = f;
        stable = 1'b1;
        for (int i = 0; i < DB; i++)
          if (lv_at(k - 2 - i) != lv_at(k - 2)) stable = 1'b0;
        if (stable) f = lv_at(k - 2);
      end else begin
        s_m[k] = lv_at(k - 2);
      end
      e_cv[k] = 0; e_wg[k] = 0; e_code[k] = '0; e_len[k] = 0; e_err[k] = 0;
    end
    t = 0; code = '0; len = 0; err = 0;
    while (t < n) begin
      if (!s_m[t]) begin
        t++;
        continue;
      end
      m = 0;
      while (t + m < n && s_m[t + m]) m++;
      t0 = t + m;
      if (t0 >= n) break;
      if (len < MS) begin
        code[len] = (m >= DASH_T);
        len++;
      end else begin
        err = 1'b1;
      end
      g = 0;
      while (t0 + g < n && !s_m[t0 + g]) g++;
      if (g < CHAR_T) begin
        t = t0 + g;
        continue;
      end
      if (t0 + CHAR_T < n) begin
        e_cv[t0 + CHAR_T]   = 1'b1;
        e_code[t0 + CHAR_T] = code;
        e_len[t0 + CHAR_T]  = len;
        e_err[t0 + CHAR_T]  = err;
      end
      code = '0; len = 0; err = 0;
      found = 1'b0;
      u = t0 + CHAR_T + 1;
      while (u < t0 + WORD_T && u < n) begin
        if (s_m[u]) begin
          found = 1'b1;
          break;
        end
        u++;
      end
      if (found) begin
        t = u;
        continue;
      end
      if (t0 + WORD_T < n) e_wg[t0 + WORD_T] = 1'b1;
      t = t0 + WORD_T + 1;
    end
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_cv"},   -1, char_valid, 0);
    chk({tag, "_code"}, -1, char_code,  0);
    chk({tag, "_len"},  -1, char_len,   0);
    chk({tag, "_err"},  -1, char_err,   0);
    chk({tag, "_wg"},   -1, word_gap,   0);
  endtask

  // Apply lv[0..n-1] one sample per cycle and compare every cycle
  task automatic run_seq(input bit do_reset);
    build_expect();
    if (do_reset) begin
      rst_n   = 1'b0;
      line_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
    end
    o_ncv = 0; o_nwg = 0; o_cv_at = -1; o_cv_last = -1; o_wg_at = -1;
    o_len = 0; o_code = '0; o_err = 0;
    for (int k = 0; k < n; k++) begin
      line_in = lv[k];
      @(posedge clk);
      #1;
      chk("char_valid", k, char_valid, e_cv[k]);
      chk("word_gap",   k, word_gap,   e_wg[k]);
      if (e_cv[k]) begin
        chk("char_code", k, char_code, e_code[k]);
        chk("char_len",  k, char_len,  e_len[k]);
        chk("char_err",  k, char_err,  e_err[k]);
      end
      if (char_valid) begin
        o_ncv++;
        if (o_cv_at < 0) o_cv_at = k;
        o_cv_last = k;
        o_code = char_code;
        o_len  = char_len;
        o_err  = char_err;
      end
      if (word_gap) begin
        o_nwg++;
        if (o_wg_at < 0) o_wg_at = k;
      end
    end
  endtask

  initial begin
    int fall, nstrobe;

    // 'A' = dot dash
    n = 0; add(0, 2); add(1, 4); add(0, 4); add(1, 12); fall = n; add(0, 30);
    run_seq(1);
    chk("A_count", 0, o_ncv, 1);
    chk("A_code",  0, o_code, 6'b000010);
    chk("A_len",   0, o_len, 2);
    chk("A_err",   0, o_err, 0);
    chk("A_latency", 0, o_cv_at, fall + LAT + CHAR_T);

    // Dash threshold: 7 cycles is still a dot, 8 is a dash
    n = 0; add(0, 2); add(1, 7); add(0, 30);
    run_seq(1);
    chk("dot7_code", 0, o_code, 0);
    chk("dot7_len",  0, o_len, 1);
    n = 0; add(0, 2); add(1, 8); add(0, 30);
    run_seq(1);
    chk("dash8_code", 0, o_code, 1);
    chk("dash8_len",  0, o_len, 1);

    // 'E' then a long idle line: one word gap, 12 cycles after the char
    n = 0; add(0, 2); add(1, 4); fall = n; add(0, 80);
    run_seq(1);
    chk("E_count",   0, o_ncv, 1);
    chk("E_cv_at",   0, o_cv_at, fall + LAT + CHAR_T);
    chk("E_wg_cnt",  0, o_nwg, 1);
    chk("E_wg_at",   0, o_wg_at, o_cv_at + WORD_T - CHAR_T);

    // 'E', short of a word gap, then 'T': only the final word gap fires
    n = 0; add(0, 2); add(1, 4); add(0, 16); add(1, 12); add(0, 40);
    run_seq(1);
    chk("ET_count",  0, o_ncv, 2);
    chk("ET_code",   0, o_code, 1);
    chk("ET_wg_cnt", 0, o_nwg, 1);
    chk("ET_wg_at",  0, o_wg_at, o_cv_last + WORD_T - CHAR_T);

    // Overflow: seven dots in one character
    n = 0; add(0, 2);
    for (int i = 0; i < 7; i++) begin
      add(1, 4);
      if (i < 6) add(0, 4);
    end
    add(0, 30);
    run_seq(1);
    chk("ovf_count", 0, o_ncv, 1);
    chk("ovf_len",   0, o_len, 6);
    chk("ovf_code",  0, o_code, 0);
    chk("ovf_err",   0, o_err, 1);

    // Stuck-high line decodes as a dash once released
    n = 0; add(0, 2); add(1, 60); add(0, 30);
    run_seq(1);
    chk("stuck_code", 0, o_code, 1);
    chk("stuck_len",  0, o_len, 1);

    // Reset after two marks discards the partial character
    n = 0; add(0, 2); add(1, 4); add(0, 4); add(1, 4); add(0, 3 + DBEN * DB);
    run_seq(1);
    chk("pre_rst_count", 0, o_ncv, 0);
    rst_n   = 1'b0;
    line_in = 1'b0;
    @(posedge clk);
    #1;
    check_zero("mid_reset");
    rst_n = 1'b1;
    nstrobe = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (char_valid || word_gap) nstrobe++;
    end
    chk("rst_no_strobe", 0, nstrobe, 0);
    n = 0; add(1, 12); add(0, 30);
    run_seq(0);
    chk("post_rst_count", 0, o_ncv, 1);
    chk("post_rst_code",  0, o_code, 1);
    chk("post_rst_len",   0, o_len, 1);

    // One-cycle pulse: a dot unless the glitch filter is built in
    n = 0; add(0, 2); add(1, 1); add(0, 40);
    run_seq(1);
    chk("glitch_count", 0, o_ncv, (DBEN != 0) ? 0 : 1);
    chk("glitch_len",   0, o_len, (DBEN != 0) ? 0 : 1);
    chk("glitch_code",  0, o_code, 0);

    // Random mark/space patterns against the model
    for (int r = 0; r < 20; r++) begin
      n = 0;
      add(0, $urandom_range(0, 5));
      while (n < MAXN - 80) begin
        add(1, ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(1, 12));
        add(0, $urandom_range(1, 24));
      end
      add(0, 40);
      run_seq(r % 3 == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
